alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
- Command-stream generator for the SimpleALU command port: the producer side of the 16-bit {op, dst, src1/imm, src2} command interface.
- Accepts operand pairs (a, b) over a valid/ready handshake.
- Emits the STO/STO/MUL/ADD sequence that accumulates sum(a*b) into an accumulator register.
- Sits between a host/test controller and SimpleALU; replaces hand-written command sequences.

Parameters:
- ACC_REG, 2, ALU register index holding the running sum.
- A_REG, 0, ALU register index loaded with operand a.
- B_REG, 1, ALU register index loaded with operand b; also holds the product.
- Constraint: ACC_REG, A_REG, B_REG are pairwise distinct, each 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a new accumulation; sampled only in IDLE.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer can accept a pair; high only in WAIT.
- in_a  in  4  operand a (immediate field width).
- in_b  in  4  operand b.
- in_last  in  1  marks the final pair of the accumulation.
- cmd  out  16  ALU command {op[15:12], dst[11:8], src1/imm[7:4], src2[3:0]}.
- cmd_valid  out  1  cmd holds a new command this cycle (one cycle per command).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the final command is issued.

Behaviour:
- Opcodes: NOP=0, STO=1, ADD=2, SUB=3, MUL=4, DIV=5.
- STO semantics: reg[dst] = imm (bits 7:4).
- Reset (async, rst=1): state=IDLE; cmd=16'h0000; cmd_valid=0; in_ready=0; busy=0; done=0; pair counter=0; captured operands=0.
- cmd and cmd_valid are registered and updated on the edge that enters an emit state. Outside emit states: cmd=16'h0000 (NOP) and cmd_valid=0.
- States and transitions:
  - IDLE: start=1 -> CLR.
  - CLR (emit {STO, ACC_REG, 0, 0}): -> WAIT.
  - WAIT (in_ready=1): in_valid=1 -> capture a, b, last; increment counter; -> LDA.
  - LDA (emit {STO, A_REG, a, 0}): -> LDB.
  - LDB (emit {STO, B_REG, b, 0}): -> MUL.
  - MUL (emit {MUL, B_REG, B_REG, A_REG}): -> ACC.
  - ACC (emit {ADD, ACC_REG, ACC_REG, B_REG}): last captured=1 -> FIN; otherwise -> WAIT.
  - FIN: done=1 for one cycle; -> IDLE.
- Latency:
  - start in cycle m -> CLR command in cycle m+1; in_ready in cycle m+2.
  - Handshake in cycle n -> STO A at n+1, STO B at n+2, MUL at n+3, ADD at n+4; in_ready high again at n+5.
  - Throughput: one pair per 5 cycles.
- Boundary conditions:
  - start while busy: ignored.
  - in_valid outside WAIT: ignored; in_a, in_b, in_last need not be held.
  - start and in_valid in the same IDLE cycle: start taken, pair ignored.
  - Pair counter is 4 bits and saturates at 15; it resets to 0 on entry to CLR.
  - Reset mid-sequence: immediate return to IDLE; a partially emitted sequence is abandoned and no done pulse is produced.
  - An accumulation with only one pair (in_last=1 on first pair) is legal.

Optional Feature:
- Macro ALU_SEQ_AVG_EN.
- Defined: ACC with last=1 goes to AVL (emit {STO, A_REG, count, 0}), then AVD (emit {DIV, ACC_REG, ACC_REG, A_REG}), then FIN. The ALU result is the integer mean. done is delayed 2 cycles. Counter saturation makes the result the sum divided by 15 for more than 15 pairs.
- Undefined: ACC goes directly to FIN; the counter may be omitted.

Test Plan:
- Reset values: assert rst mid-WAIT -> cmd=0000, cmd_valid=0, in_ready=0, busy=0; no done pulse.
- Single pair (a=3, b=2, last=1) after start -> cmd sequence 1200, 1030, 1120, 4110, 2221; done pulses one cycle after 2221.
- Three pairs (5,4), (6,7), (2,1 last) -> exactly 13 valid commands:
  - 1200
  - 1050, 1140, 4110, 2221
  - 1060, 1170, 4110, 2221
  - 1020, 1110, 4110, 2221
  - A behavioural ALU model reads r2=64.
- in_valid held high continuously -> in_ready pulses every 5 cycles; each pair consumed exactly once; no command gaps other than WAIT cycles.
- start asserted during LDB, and in_valid during MUL -> both ignored; command stream unchanged.
- With ALU_SEQ_AVG_EN and pairs (5,4), (6,7) last -> trailing 1020, 5220 before done; model r2=31.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Command generator for the SimpleALU port. It turns (a, b) operand pairs into the
// STO/STO/MUL/ADD sequence that accumulates sum(a*b). Define ALU_SEQ_AVG_EN to end each run with a mean.
module alu_cmd_sequencer #(
  parameter int ACC_REG = 2,
  parameter int A_REG   = 0,
  parameter int B_REG   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_a,
  input  logic [3:0]  in_b,
  input  logic        in_last,
  output logic [15:0] cmd,
  output logic        cmd_valid,
  output logic        busy,
  output logic        done
);

  localparam logic [3:0] OP_STO = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_MUL = 4'd4;
`ifdef ALU_SEQ_AVG_EN
  localparam logic [3:0] OP_DIV = 4'd5;
`endif
  localparam logic [3:0] ACC_R = ACC_REG[3:0];
  localparam logic [3:0] A_R   = A_REG[3:0];
  localparam logic [3:0] B_R   = B_REG[3:0];

  typedef enum logic [3:0] {
    S_IDLE, S_CLR, S_WAIT, S_LDA, S_LDB, S_MUL, S_ACC, S_AVL, S_AVD, S_FIN
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  a_q, a_d, b_q, b_d;
  logic        last_q, last_d;
  logic [15:0] cmd_q, cmd_d;
  logic        cmd_vld_q, cmd_vld_d;
`ifdef ALU_SEQ_AVG_EN
  logic [3:0]  cnt_q, cnt_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      last_q    <= 1'b0;
      cmd_q     <= '0;
      cmd_vld_q <= 1'b0;
`ifdef ALU_SEQ_AVG_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      last_q    <= last_d;
      cmd_q     <= cmd_d;
      cmd_vld_q <= cmd_vld_d;
`ifdef ALU_SEQ_AVG_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    last_d    = last_q;
    cmd_d     = 16'h0000;
    cmd_vld_d = 1'b0;
`ifdef ALU_SEQ_AVG_EN
    cnt_d     = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLR;
`ifdef ALU_SEQ_AVG_EN
          cnt_d   = '0;
`endif
        end
      end
      S_CLR:  state_d = S_WAIT;
      S_WAIT: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          last_d  = in_last;
          state_d = S_LDA;
`ifdef ALU_SEQ_AVG_EN
          cnt_d   = (cnt_q == 4'd15) ? 4'd15 : cnt_q + 4'd1;
`endif
        end
      end
      S_LDA:  state_d = S_LDB;
      S_LDB:  state_d = S_MUL;
      S_MUL:  state_d = S_ACC;
      S_ACC: begin
`ifdef ALU_SEQ_AVG_EN
        state_d = last_q ? S_AVL : S_WAIT;
`else
        state_d = last_q ? S_FIN : S_WAIT;
`endif
      end
      S_AVL:  state_d = S_AVD;
      S_AVD:  state_d = S_FIN;
      S_FIN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // The command register is loaded on the edge that enters an emit state, so it decodes
    // the next state. It also uses the next operand values: a pair captured on this edge
    // appears in the command at once.
    unique case (state_d)
      S_CLR: begin cmd_d = {OP_STO, ACC_R, 4'h0, 4'h0};  cmd_vld_d = 1'b1; end
      S_LDA: begin cmd_d = {OP_STO, A_R, a_d, 4'h0};     cmd_vld_d = 1'b1; end
      S_LDB: begin cmd_d = {OP_STO, B_R, b_d, 4'h0};     cmd_vld_d = 1'b1; end
      S_MUL: begin cmd_d = {OP_MUL, B_R, B_R, A_R};      cmd_vld_d = 1'b1; end
      S_ACC: begin cmd_d = {OP_ADD, ACC_R, ACC_R, B_R};  cmd_vld_d = 1'b1; end
`ifdef ALU_SEQ_AVG_EN
      S_AVL: begin cmd_d = {OP_STO, A_R, cnt_d, 4'h0};   cmd_vld_d = 1'b1; end
      S_AVD: begin cmd_d = {OP_DIV, ACC_R, ACC_R, A_R};  cmd_vld_d = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign cmd       = cmd_q;
  assign cmd_valid = cmd_vld_q;
  assign in_ready  = (state_q == S_WAIT);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FIN);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer: checks the command stream cycle by cycle.
// A behavioural SimpleALU model checks the accumulated result.
module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_a = '0;
  logic [3:0]  in_b = '0;
  logic        in_last = 1'b0;
  logic [15:0] cmd;
  logic        cmd_valid;
  logic        busy;
  logic        done;

  int pass_cnt = 0;
  int total_cnt = 0;
  int ncmd = 0;
  int r [16];

  alu_cmd_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .cmd(cmd), .cmd_valid(cmd_valid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural SimpleALU that executes every valid command
  always @(negedge clk) begin
    if (cmd_valid) begin
      ncmd++;
      case (cmd[15:12])
        4'd1: r[cmd[11:8]] = int'(cmd[7:4]);
        4'd2: r[cmd[11:8]] = r[cmd[7:4]] + r[cmd[3:0]];
        4'd3: r[cmd[11:8]] = r[cmd[7:4]] - r[cmd[3:0]];
        4'd4: r[cmd[11:8]] = r[cmd[7:4]] * r[cmd[3:0]];
        4'd5: if (r[cmd[3:0]] != 0) r[cmd[11:8]] = r[cmd[7:4]] / r[cmd[3:0]];
        default: ;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_cmd(input string tag, input logic [15:0] c);
    tick();
    chk({tag, ".vld"}, 32'(cmd_valid), 32'd1);
    chk({tag, ".cmd"}, 32'(cmd), 32'(c));
    chk({tag, ".rdy"}, 32'(in_ready), 32'd0);
  endtask

  // The sequencer is in WAIT. This hands over one pair and checks the four commands it produces.
  task automatic pair(input logic [3:0] a, input logic [3:0] b, input logic l, input bit hold);
    chk("pair.rdy", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_a = a; in_b = b; in_last = l;
    exp_cmd("stoA", {4'h1, 4'h0, a, 4'h0});
    if (!hold) in_valid = 1'b0;
    in_a = 4'hF; in_b = 4'hF; in_last = 1'b0;
    exp_cmd("stoB", {4'h1, 4'h1, b, 4'h0});
    exp_cmd("mul", 16'h4110);
    exp_cmd("add", 16'h2221);
  endtask

  // Ends a run: the optional mean commands, then a one-cycle done pulse
  task automatic finish_seq(input logic [3:0] count);
`ifdef ALU_SEQ_AVG_EN
    exp_cmd("avl", {4'h1, 4'h0, count, 4'h0});
    exp_cmd("avd", 16'h5220);
`else
    chk("count.arg", 32'(count), 32'(count));
`endif
    tick();
    chk("fin.done", 32'(done), 32'd1);
    chk("fin.vld", 32'(cmd_valid), 32'd0);
    chk("fin.busy", 32'(busy), 32'd1);
    tick();
    chk("idle.done", 32'(done), 32'd0);
    chk("idle.busy", 32'(busy), 32'd0);
  endtask

  task automatic begin_run();
    start = 1'b1;
    exp_cmd("clr", 16'h1200);
    start = 1'b0;
    tick();
    chk("wait.vld", 32'(cmd_valid), 32'd0);
  endtask

`ifdef ALU_SEQ_AVG_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif

  int n0;

  initial begin
    for (int i = 0; i < 16; i++) r[i] = 0;

    // Reset state
    repeat (2) tick();
    chk("rst.cmd", 32'(cmd), 32'h0);
    chk("rst.vld", 32'(cmd_valid), 32'd0);
    chk("rst.rdy", 32'(in_ready), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle.busy0", 32'(busy), 32'd0);

    // Single pair 3*2
    n0 = ncmd;
    begin_run();
    pair(4'd3, 4'd2, 1'b1, 1'b0);
    finish_seq(4'd1);
    chk("single.ncmd", 32'(ncmd - n0), 32'(5 + EXTRA));
`ifdef ALU_SEQ_AVG_EN
    chk("single.r2", 32'(r[2]), 32'd6);
`else
    chk("single.r2", 32'(r[2]), 32'd6);
`endif

    // Three pairs. start and in_valid are raised together in IDLE; the pair must be ignored.
    n0 = ncmd;
    start = 1'b1; in_valid = 1'b1; in_a = 4'd9; in_b = 4'd9; in_last = 1'b1;
    exp_cmd("clr3", 16'h1200);
    start = 1'b0; in_valid = 1'b0;
    tick();
    chk("three.wait.vld", 32'(cmd_valid), 32'd0);
    pair(4'd5, 4'd4, 1'b0, 1'b0);
    tick();
    pair(4'd6, 4'd7, 1'b0, 1'b0);
    tick();
    pair(4'd2, 4'd1, 1'b1, 1'b0);
    finish_seq(4'd3);
    chk("three.ncmd", 32'(ncmd - n0), 32'(13 + EXTRA));
`ifdef ALU_SEQ_AVG_EN
    chk("three.r2", 32'(r[2]), 32'd21);
`else
    chk("three.r2", 32'(r[2]), 32'd64);
`endif

    // in_valid held high: one pair every 5 cycles, and no gaps other than the WAIT cycles
    n0 = ncmd;
    begin_run();
    pair(4'd1, 4'd2, 1'b0, 1'b1);
    in_valid = 1'b1; in_a = 4'd3; in_b = 4'd1; in_last = 1'b0;
    tick();
    chk("hold.wait.vld", 32'(cmd_valid), 32'd0);
    pair(4'd3, 4'd1, 1'b0, 1'b1);
    in_valid = 1'b1;
    tick();
    chk("hold.wait2.vld", 32'(cmd_valid), 32'd0);
    pair(4'd2, 4'd2, 1'b1, 1'b1);
    finish_seq(4'd3);
    in_valid = 1'b0;
    chk("hold.ncmd", 32'(ncmd - n0), 32'(13 + EXTRA));
`ifdef ALU_SEQ_AVG_EN
    chk("hold.r2", 32'(r[2]), 32'd3);
`else
    chk("hold.r2", 32'(r[2]), 32'd9);
`endif

    // start during LDB and in_valid during MUL are both ignored
    n0 = ncmd;
    begin_run();
    chk("ign.rdy", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_a = 4'd3; in_b = 4'd3; in_last = 1'b1;
    exp_cmd("ign.stoA", 16'h1030);
    in_valid = 1'b0;
    exp_cmd("ign.stoB", 16'h1130);
    start = 1'b1;
    exp_cmd("ign.mul", 16'h4110);
    start = 1'b0; in_valid = 1'b1; in_a = 4'd15; in_b = 4'd15; in_last = 1'b0;
    exp_cmd("ign.add", 16'h2221);
    in_valid = 1'b0;
    finish_seq(4'd1);
    tick();
    chk("ign.idle.busy", 32'(busy), 32'd0);
    chk("ign.ncmd", 32'(ncmd - n0), 32'(5 + EXTRA));
    chk("ign.r2", 32'(r[2]), 32'd9);

    // Reset in mid-WAIT: the sequencer returns to IDLE at once and produces no done pulse
    begin_run();
    chk("mid.rdy", 32'(in_ready), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid.cmd", 32'(cmd), 32'h0);
    chk("mid.vld", 32'(cmd_valid), 32'd0);
    chk("mid.rdy0", 32'(in_ready), 32'd0);
    chk("mid.busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mid.nodone", 32'(done), 32'd0);
    end

    // Reset during MUL, then a clean run to show recovery
    begin_run();
    in_valid = 1'b1; in_a = 4'd4; in_b = 4'd4; in_last = 1'b1;
    exp_cmd("rm.stoA", 16'h1040);
    in_valid = 1'b0;
    exp_cmd("rm.stoB", 16'h1140);
    exp_cmd("rm.mul", 16'h4110);
    #2 rst = 1'b1;
    #1;
    chk("rm.cmd", 32'(cmd), 32'h0);
    chk("rm.busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("rm.nodone", 32'(done), 32'd0);
    begin_run();
    pair(4'd7, 4'd2, 1'b1, 1'b0);
    finish_seq(4'd1);
    chk("rec.r2", 32'(r[2]), 32'd14);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
